// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard control unit.
package hazard_pkg;
  localparam int REG_AW = 5;
  localparam int FWD_RF = 0;
  typedef enum logic [1:0] {RUN = 2'd0, LOAD_STALL = 2'd1, MC_BUSY = 2'd2} state_t;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: priority comparator picking the youngest matching forward source.
module fwd_select import hazard_pkg::*; #(
  parameter int N  = 3,
  parameter int SW = 2
) (
  input  logic [REG_AW-1:0]   rs,
  input  logic [REG_AW*N-1:0] rd_stage,
  input  logic [N-1:0]        regwen_stage,
  input  logic                en,
  output logic [SW-1:0]       sel
);
  // scanning downward lets the lowest (youngest) stage overwrite older matches
  always_comb begin
    sel = SW'(FWD_RF);
    for (int k = N - 1; k >= 0; k--)
      if (regwen_stage[k] && rd_stage[k*REG_AW +: REG_AW] == rs && rs != '0) sel = SW'(k + 1);
    if (!en) sel = '0;
  end
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: operand forwarding plus load-use, multi-cycle and branch
// stall/flush sequencing for the ID/EX boundary.
module hazard_ctrl_unit import hazard_pkg::*; #(
  parameter int NUM_FWD_STAGES = 3,
  parameter int LOAD_LATENCY   = 1,
  parameter int CNT_W          = 32
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [REG_AW-1:0]                  rs1_id,
  input  logic [REG_AW-1:0]                  rs2_id,
  input  logic                               use_rs1_id,
  input  logic                               use_rs2_id,
  input  logic [REG_AW-1:0]                  rs1_ex,
  input  logic [REG_AW-1:0]                  rs2_ex,
  input  logic [REG_AW-1:0]                  rd_ex,
  input  logic                               regwen_ex,
  input  logic                               memread_ex,
  input  logic [REG_AW*NUM_FWD_STAGES-1:0]   rd_stage,
  input  logic [NUM_FWD_STAGES-1:0]          regwen_stage,
  input  logic                               branch_taken_ex,
  input  logic                               mc_start_ex,
  input  logic                               mc_done,
  output logic [$clog2(NUM_FWD_STAGES+1)-1:0] fwd_sel_a,
  output logic [$clog2(NUM_FWD_STAGES+1)-1:0] fwd_sel_b,
  output logic                               stall_if,
  output logic                               stall_id,
  output logic                               stall_ex,
  output logic                               flush_id,
  output logic                               flush_ex,
  output logic                               bubble_ma,
  output logic [1:0]                         state_o,
  output logic [CNT_W-1:0]                   stall_count
);
  localparam int SEL_W = $clog2(NUM_FWD_STAGES + 1);
  localparam int LCW   = LOAD_LATENCY > 1 ? $clog2(LOAD_LATENCY) : 1;
  state_t state, state_nxt;
  logic [LCW-1:0] cnt, cnt_nxt;
  logic lu, s_if, s_ex, f_id, f_ex;
  fwd_select #(.N(NUM_FWD_STAGES), .SW(SEL_W)) u_fwd_a (
    .rs(rs1_ex), .rd_stage(rd_stage), .regwen_stage(regwen_stage), .en(reset_n), .sel(fwd_sel_a)
  );
  fwd_select #(.N(NUM_FWD_STAGES), .SW(SEL_W)) u_fwd_b (
    .rs(rs2_ex), .rd_stage(rd_stage), .regwen_stage(regwen_stage), .en(reset_n), .sel(fwd_sel_b)
  );
  assign lu = memread_ex && regwen_ex && rd_ex != '0 &&
              ((use_rs1_id && rd_ex == rs1_id) || (use_rs2_id && rd_ex == rs2_id));
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    s_if      = 1'b0;
    s_ex      = 1'b0;
    f_id      = 1'b0;
    f_ex      = 1'b0;
    case (state)
      RUN: begin
        if (branch_taken_ex) begin
          f_id = 1'b1;
          f_ex = 1'b1;
        end else if (mc_start_ex) begin
          s_if      = 1'b1;
          s_ex      = 1'b1;
          state_nxt = mc_done ? RUN : MC_BUSY;
        end else if (lu) begin
          s_if = 1'b1;
          f_ex = 1'b1;
          if (LOAD_LATENCY > 1) begin
            state_nxt = LOAD_STALL;
            cnt_nxt   = LCW'(LOAD_LATENCY - 1);
          end
        end
      end
      LOAD_STALL: begin
        s_if      = 1'b1;
        f_ex      = 1'b1;
        cnt_nxt   = cnt - 1'b1;
        state_nxt = cnt <= LCW'(1) ? RUN : LOAD_STALL;
      end
      MC_BUSY: begin
        s_if      = !mc_done;
        s_ex      = !mc_done;
        state_nxt = mc_done ? RUN : MC_BUSY;
      end
      default: state_nxt = RUN;
    endcase
  end
  assign stall_if  = s_if && reset_n;
  assign stall_id  = s_if && reset_n;
  assign stall_ex  = s_ex && reset_n;
  assign bubble_ma = s_ex && reset_n;
  assign flush_id  = f_id && reset_n;
  assign flush_ex  = f_ex && reset_n;
  assign state_o   = state;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      cnt         <= '0;
      stall_count <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (stall_if && !(&stall_count)) stall_count <= stall_count + CNT_W'(1);
    end
  end
endmodule
